// File: rtl/cu_pkg.sv
// Shared encodings for the NN-simulator instruction decoder: opcodes, ALU codes
// and the bundled control word.
package cu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_MAC  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hB;
  localparam logic [3:0] OP_SW   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_MUL  = 3'b011;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic       pc_en;
    logic       mem_read;
    logic [2:0] alu1;
    logic [2:0] alu2;
  } ctrl_t;

  // Register-register arithmetic: write rd, keep fetching.
  function automatic ctrl_t rtype(input logic [2:0] a1, input logic [2:0] a2);
    ctrl_t c;
    c           = '0;
    c.reg_write = 1'b1;
    c.reg_dst   = 1'b1;
    c.pc_en     = 1'b1;
    c.alu1      = a1;
    c.alu2      = a2;
    return c;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode -> control word table; anything not listed behaves as NOP.
module cu_decode
  import cu_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl       = '0;
    ctrl.pc_en = 1'b1;
    ctrl.alu1  = ALU_PASS;
    ctrl.alu2  = ALU_PASS;
    case (opcode)
      OP_ADD:  ctrl = rtype(ALU_ADD, ALU_PASS);
      OP_SUB:  ctrl = rtype(ALU_SUB, ALU_PASS);
      OP_MUL:  ctrl = rtype(ALU_MUL, ALU_PASS);
      // MAC: ALU2 adds the product to rd, giving rd = rs*rt + rd.
      OP_MAC:  ctrl = rtype(ALU_MUL, ALU_ADD);
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu1      = ALU_ADD;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu1       = ALU_ADD;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu1      = ALU_ADD;
      end
      OP_HALT: ctrl = '0;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main instruction decoder: registered control outputs with a sticky halt that
// only reset can clear.
module control_unit
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       MemWrite,
  output logic [2:0] ALUControl1,
  output logic [2:0] ALUControl2,
  output logic       ALUSrc,
  output logic       RegDst,
  output logic       PCEn,
  output logic       MemRead
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  halted;

  cu_decode u_decode (
    .opcode (opcode),
    .ctrl   (ctrl_d)
  );

  // Reset takes priority, so a HALT seen on a reset edge never sets the flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      halted <= 1'b0;
    end else begin
      ctrl_q <= halted ? '0 : ctrl_d;
      if (opcode == OP_HALT) halted <= 1'b1;
    end
  end

  assign RegWrite    = ctrl_q.reg_write;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign MemWrite    = ctrl_q.mem_write;
  assign ALUSrc      = ctrl_q.alu_src;
  assign RegDst      = ctrl_q.reg_dst;
  assign PCEn        = ctrl_q.pc_en;
  assign MemRead     = ctrl_q.mem_read;
  assign ALUControl1 = ctrl_q.alu1;
  assign ALUControl2 = ctrl_q.alu2;

endmodule

// File: tb/tb_control_unit.sv
// Directed and randomized checks of control_unit against a hand-written decode table.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, PCEn, MemRead;
  logic [2:0] ALUControl1, ALUControl2;

  int n_vec = 0;
  int n_bad = 0;

  control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .MemWrite    (MemWrite),
    .ALUControl1 (ALUControl1),
    .ALUControl2 (ALUControl2),
    .ALUSrc      (ALUSrc),
    .RegDst      (RegDst),
    .PCEn        (PCEn),
    .MemRead     (MemRead)
  );

  always #5 clk = ~clk;

  // Word order: RegWrite MemtoReg MemWrite ALUSrc RegDst PCEn MemRead | ALU1 | ALU2
  function automatic logic [12:0] obs();
    return {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, PCEn, MemRead, ALUControl1, ALUControl2};
  endfunction

  function automatic logic [12:0] table_of(input logic [3:0] op);
    case (op)
      4'h1:    return 13'b1000110_010_000;
      4'h2:    return 13'b1000110_110_000;
      4'h3:    return 13'b1000110_011_000;
      4'h4:    return 13'b1000110_011_010;
      4'h9:    return 13'b1001010_010_000;
      4'hB:    return 13'b1101011_010_000;
      4'hE:    return 13'b0011010_010_000;
      4'hF:    return 13'b0000000_000_000;
      default: return 13'b0000010_000_000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, want);
    end
  endtask

  task automatic cyc(input logic [3:0] op, input logic rst);
    @(negedge clk);
    opcode = op;
    rst_n  = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] op;
    logic       r;
    logic       m_halt;
    logic [12:0] want;
    logic [3:0] unused_ops [7] = '{4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hC, 4'hD};

    rst_n  = 1'b0;
    opcode = 4'h0;

    cyc(4'h0, 1'b0); chk("reset_edge1", obs(), 13'd0);
    cyc(4'h0, 1'b0); chk("reset_edge2", obs(), 13'd0);
    cyc(4'h0, 1'b1); chk("nop_after_reset", obs(), 13'b0000010_000_000);

    cyc(4'h1, 1'b1);
    chk("add_regwrite", {12'd0, RegWrite}, 13'd1);
    chk("add_regdst",   {12'd0, RegDst},   13'd1);
    chk("add_alu1",     {10'd0, ALUControl1}, 13'b010);
    cyc(4'h9, 1'b1);
    chk("addi_alusrc",  {12'd0, ALUSrc}, 13'd1);
    chk("addi_regdst",  {12'd0, RegDst}, 13'd0);
    cyc(4'h2, 1'b1);
    chk("sub_alu1",     {10'd0, ALUControl1}, 13'b110);
    cyc(4'h3, 1'b1);
    chk("mul_alus",     {7'd0, ALUControl1, ALUControl2}, 13'b011_000);
    cyc(4'h4, 1'b1);
    chk("mac_alus",     {7'd0, ALUControl1, ALUControl2}, 13'b011_010);
    chk("mac_word",     obs(), 13'b1000110_011_010);

    cyc(4'hE, 1'b1);
    chk("sw_mem",  {9'd0, MemWrite, RegWrite, ALUSrc, MemRead}, 13'b1010);
    cyc(4'hB, 1'b1);
    chk("lw_mem",  {8'd0, RegWrite, MemtoReg, MemRead, MemWrite, 1'b0}, 13'b11100);
    chk("lw_alu1", {10'd0, ALUControl1}, 13'b010);

    cyc(4'hF, 1'b1); chk("halt_edge",   obs(), 13'd0);
    cyc(4'h1, 1'b1); chk("halt_add",    obs(), 13'd0);
    cyc(4'hB, 1'b1); chk("halt_lw",     obs(), 13'd0);
    cyc(4'h0, 1'b1); chk("halt_nop",    obs(), 13'd0);
    cyc(4'h1, 1'b0); chk("halt_reset",  obs(), 13'd0);
    cyc(4'h1, 1'b1); chk("resume_add",  obs(), 13'b1000110_010_000);

    // HALT coinciding with reset must not latch the flag.
    cyc(4'hF, 1'b0); chk("rst_halt_same_edge", obs(), 13'd0);
    cyc(4'h1, 1'b1); chk("no_halt_after_rst",  obs(), 13'b1000110_010_000);

    foreach (unused_ops[i]) begin
      cyc(unused_ops[i], 1'b1);
      chk($sformatf("unused_%h", unused_ops[i]), obs(), 13'b0000010_000_000);
    end

    m_halt = 1'b0;
    for (int k = 0; k < 200; k++) begin
      op = 4'($urandom_range(0, 15));
      r  = !(m_halt && ($urandom_range(0, 3) == 0));
      cyc(op, r);
      if (!r) begin
        want   = 13'd0;
        m_halt = 1'b0;
      end else begin
        want = m_halt ? 13'd0 : table_of(op);
        if (op == 4'hF) m_halt = 1'b1;
      end
      chk($sformatf("rand_%0d_op%h", k, op), obs(), want);
      chk($sformatf("rand_%0d_excl", k),
          {11'd0, MemRead & MemWrite, MemtoReg & ~(RegWrite & MemRead)}, 13'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
